// File: rtl/batch_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : batch_cnt_pkg
//  Description : Shared types and default sizing for the batch sample
//                counter: the WRAP/HOLD mode encoding and the default
//                channel count, count width and tally width.
//  Revision    : 1.0  - initial release
// ============================================================================
package batch_cnt_pkg;

    // Behaviour once a channel's count reaches batch_size.
    typedef enum logic {
        MODE_WRAP = 1'b0,   // next strobe restarts the batch at 1
        MODE_HOLD = 1'b1    // count freezes until acknowledged
    } mode_e;

    localparam int c_NUM_CH  = 4;
    localparam int c_CNT_W   = 10;
    localparam int c_BATCH_W = 8;

endpackage : batch_cnt_pkg
`default_nettype wire

// File: rtl/batch_ch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : batch_ch_counter
//  Description : One channel of the batch sample counter. Counts sample
//                strobes up to a shared batch length, flags completion,
//                keeps a saturating tally of completed batches and a sticky
//                flag for samples dropped while a batch is held.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_cnt_up        - sample strobe
//                i_clear         - per-channel synchronous clear
//                i_ack           - batch acknowledge (HOLD mode only)
//                i_batch_size    - batch length, 0 disables counting
//                i_mode          - MODE_WRAP / MODE_HOLD
//                o_count         - registered sample count
//                o_done          - registered batch-complete flag
//                o_overflow      - registered sticky dropped-sample flag
//                o_tally         - registered saturating batch tally
//  Revision    : 1.0  - initial release
// ============================================================================
module batch_ch_counter
    import batch_cnt_pkg::*;
#(
    parameter int CNT_W   = c_CNT_W,
    parameter int BATCH_W = c_BATCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cnt_up,
    input  logic               i_clear,
    input  logic               i_ack,
    input  logic [CNT_W-1:0]   i_batch_size,
    input  mode_e              i_mode,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_done,
    output logic               o_overflow,
    output logic [BATCH_W-1:0] o_tally
);

    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO = '0;

    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic               r_overflow;
    logic [BATCH_W-1:0] r_tally;

    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_done_nxt;
    logic               w_ovf_set;
    logic               w_complete;
    logic               w_disabled;
    logic               w_at_size;
    logic               w_holding;
    logic               w_size_is_one;

    assign w_disabled    = (i_batch_size == c_ZERO);
    assign w_at_size     = (r_count == i_batch_size);
    assign w_size_is_one = (i_batch_size == c_ONE);
    assign w_holding     = (i_mode == MODE_HOLD) && w_at_size && !w_disabled;
    // Only used when r_count < batch_size, so it can never wrap.
    assign w_count_inc   = r_count + c_ONE;

    always_comb begin
        w_count_nxt = r_count;
        // Without a count change, done survives only while the count still
        // matches the (possibly changed) batch length.
        w_done_nxt  = r_done && w_at_size;
        w_ovf_set   = 1'b0;
        w_complete  = 1'b0;

        if (w_disabled) begin
            w_count_nxt = c_ZERO;
            w_done_nxt  = 1'b0;
        end else if (w_holding) begin
            if (i_ack) begin
                // Release the held batch; a coincident strobe becomes the
                // first sample of the next batch.
                w_count_nxt = i_cnt_up ? c_ONE : c_ZERO;
                w_complete  = i_cnt_up && w_size_is_one;
                w_done_nxt  = w_complete;
            end else if (i_cnt_up) begin
                w_ovf_set = 1'b1;
            end
        end else if (i_cnt_up) begin
            if (r_count < i_batch_size) begin
                w_count_nxt = w_count_inc;
                w_complete  = (w_count_inc == i_batch_size);
            end else begin
                // Either a finished WRAP batch or a batch length lowered
                // below the count. Only the former can complete a
                // single-sample batch.
                w_count_nxt = c_ONE;
                w_complete  = w_at_size && w_size_is_one;
            end
            w_done_nxt = w_complete;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_tally    <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_complete && !(&r_tally)) begin
                r_tally <= r_tally + BATCH_W'(1);
            end
        end
    end

    assign o_count    = r_count;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_tally    = r_tally;

endmodule : batch_ch_counter
`default_nettype wire

// File: rtl/batch_sample_counter.sv
`default_nettype none
// ============================================================================
//  Module      : batch_sample_counter
//  Description : NUM_CH independent batch sample counters sharing a batch
//                length and mode, with packed per-channel outputs and a
//                combined any-done flag.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                cnt_up[N]     - per-channel sample strobe
//                clear[N]      - per-channel synchronous clear
//                ack[N]        - per-channel batch acknowledge (HOLD)
//                batch_size    - shared batch length, 0 disables counting
//                mode          - 0 = WRAP, 1 = HOLD
//                count_out     - channel i at [i*CNT_W +: CNT_W]
//                batch_done[N] - per-channel batch-complete flag
//                overflow[N]   - per-channel sticky dropped-sample flag
//                batch_tally   - channel i at [i*BATCH_W +: BATCH_W]
//                any_done      - OR of batch_done
//  Revision    : 1.0  - initial release
// ============================================================================
module batch_sample_counter
    import batch_cnt_pkg::*;
#(
    parameter int NUM_CH  = c_NUM_CH,
    parameter int CNT_W   = c_CNT_W,
    parameter int BATCH_W = c_BATCH_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         cnt_up,
    input  logic [NUM_CH-1:0]         clear,
    input  logic [NUM_CH-1:0]         ack,
    input  logic [CNT_W-1:0]          batch_size,
    input  logic                      mode,
    output logic [NUM_CH*CNT_W-1:0]   count_out,
    output logic [NUM_CH-1:0]         batch_done,
    output logic [NUM_CH-1:0]         overflow,
    output logic [NUM_CH*BATCH_W-1:0] batch_tally,
    output logic                      any_done
);

    mode_e w_mode;
    assign w_mode = mode_e'(mode);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        batch_ch_counter #(
            .CNT_W   (CNT_W),
            .BATCH_W (BATCH_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_cnt_up     (cnt_up[g]),
            .i_clear      (clear[g]),
            .i_ack        (ack[g]),
            .i_batch_size (batch_size),
            .i_mode       (w_mode),
            .o_count      (count_out[g*CNT_W +: CNT_W]),
            .o_done       (batch_done[g]),
            .o_overflow   (overflow[g]),
            .o_tally      (batch_tally[g*BATCH_W +: BATCH_W])
        );
    end

    // OR of registered flags only; no input reaches this output directly.
    assign any_done = |batch_done;

endmodule : batch_sample_counter
`default_nettype wire

// File: tb/tb_batch_sample_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_batch_sample_counter
//  Description : Directed self-checking bench for batch_sample_counter.
//                A default 4-channel instance covers the counting, HOLD,
//                clear and batch-size cases; a 1-channel BATCH_W = 2
//                instance covers tally saturation.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_batch_sample_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cnt_up, clear, ack;
    logic [9:0]  bs;
    logic        mode;
    logic [39:0] count_out;
    logic [3:0]  batch_done, overflow;
    logic [31:0] batch_tally;
    logic        any_done;

    logic        cnt_up2, clear2, ack2, mode2;
    logic [9:0]  bs2;
    logic [9:0]  count2;
    logic        done2, ovf2, any2;
    logic [1:0]  tally2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    batch_sample_counter dut (
        .clk(clk), .rst(rst), .cnt_up(cnt_up), .clear(clear), .ack(ack),
        .batch_size(bs), .mode(mode), .count_out(count_out),
        .batch_done(batch_done), .overflow(overflow),
        .batch_tally(batch_tally), .any_done(any_done)
    );

    batch_sample_counter #(.NUM_CH(1), .CNT_W(10), .BATCH_W(2)) dut2 (
        .clk(clk), .rst(rst), .cnt_up(cnt_up2), .clear(clear2), .ack(ack2),
        .batch_size(bs2), .mode(mode2), .count_out(count2),
        .batch_done(done2), .overflow(ovf2),
        .batch_tally(tally2), .any_done(any2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs are changed 1 time unit after an edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            cnt_up[ch] = 1'b1;
            tick();
        end
        cnt_up[ch] = 1'b0;
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(count_out[ch*10 +: 10]);
    endfunction

    function automatic logic [31:0] tly(input int ch);
        return 32'(batch_tally[ch*8 +: 8]);
    endfunction

    initial begin
        rst = 1'b1; cnt_up = '0; clear = '0; ack = '0; bs = 10'd0; mode = 1'b0;
        cnt_up2 = 1'b0; clear2 = 1'b0; ack2 = 1'b0; bs2 = 10'd0; mode2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_count", 32'(|count_out), 0);
        check("reset_done", 32'(batch_done), 0);
        check("reset_tally", batch_tally, 0);
        check("reset_any", 32'(any_done), 0);

        // WRAP, batch of 1000 on ch0
        mode = 1'b0; bs = 10'd1000;
        strobe(0, 999);
        check("wrap_cnt999", cnt(0), 999);
        check("wrap_done999", 32'(batch_done[0]), 0);
        strobe(0, 1);
        check("wrap_cnt1000", cnt(0), 1000);
        check("wrap_done1000", 32'(batch_done[0]), 1);
        check("wrap_tally", tly(0), 1);
        check("wrap_any", 32'(any_done), 1);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        check("wrap_ack_ignored", cnt(0), 1000);
        strobe(0, 1);
        check("wrap_restart_cnt", cnt(0), 1);
        check("wrap_restart_done", 32'(batch_done[0]), 0);
        check("wrap_restart_tally", tly(0), 1);
        clear[0] = 1'b1; tick(); clear[0] = 1'b0;
        check("clear_ch0", cnt(0), 0);

        // HOLD, batch of 4, six strobes on ch1
        mode = 1'b1; bs = 10'd4;
        strobe(1, 6);
        check("hold_cnt", cnt(1), 4);
        check("hold_done", 32'(batch_done[1]), 1);
        check("hold_ovf", 32'(overflow[1]), 1);
        check("hold_tally", tly(1), 1);
        ack[1] = 1'b1; cnt_up[1] = 1'b1; tick(); ack[1] = 1'b0; cnt_up[1] = 1'b0;
        check("ack_up_cnt", cnt(1), 1);
        check("ack_up_done", 32'(batch_done[1]), 0);
        check("ack_ovf_sticky", 32'(overflow[1]), 1);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        check("ack_not_holding", cnt(1), 1);

        // clear > ack > cnt_up on ch2
        strobe(2, 5);
        check("ch2_ovf", 32'(overflow[2]), 1);
        ack[2] = 1'b1; tick(); ack[2] = 1'b0;
        check("ch2_ack_only", cnt(2), 0);
        strobe(2, 3);
        check("ch2_cnt3", cnt(2), 3);
        clear[2] = 1'b1; ack[2] = 1'b1; cnt_up[2] = 1'b1; tick();
        clear[2] = 1'b0; ack[2] = 1'b0; cnt_up[2] = 1'b0;
        check("clr_cnt", cnt(2), 0);
        check("clr_tally", tly(2), 0);
        check("clr_ovf", 32'(overflow[2]), 0);

        // Mode switch while holding: WRAP rules from the held count
        strobe(1, 3);
        check("sw_hold_cnt", cnt(1), 4);
        check("sw_hold_tally", tly(1), 2);
        mode = 1'b0; cnt_up[1] = 1'b1; tick(); cnt_up[1] = 1'b0;
        check("sw_wrap_cnt", cnt(1), 1);
        check("sw_wrap_done", 32'(batch_done[1]), 0);

        // Batch size lowered below count, then disabled, on ch3
        bs = 10'd10;
        strobe(3, 7);
        check("lower_pre", cnt(3), 7);
        bs = 10'd5;
        strobe(3, 1);
        check("lower_cnt", cnt(3), 1);
        check("lower_done", 32'(batch_done[3]), 0);
        check("lower_tally", tly(3), 0);
        bs = 10'd0;
        strobe(3, 3);
        check("zero_cnt", cnt(3), 0);
        check("zero_ovf", 32'(overflow[3]), 0);
        check("zero_done", 32'(batch_done[3]), 0);

        // Tally saturation with BATCH_W = 2, batch of 1
        bs2 = 10'd1; mode2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt_up2 = 1'b1; tick();
        end
        cnt_up2 = 1'b0;
        check("sat_tally2", 32'(tally2), 2);
        check("sat_done", 32'(done2), 1);
        for (int i = 0; i < 3; i++) begin
            cnt_up2 = 1'b1; tick();
        end
        cnt_up2 = 1'b0;
        check("sat_tally", 32'(tally2), 3);
        check("sat_cnt", 32'(count2), 1);

        // Reset mid-hold
        mode = 1'b1; bs = 10'd4;
        strobe(0, 5);
        check("prerst_done", 32'(batch_done[0]), 1);
        rst = 1'b1; cnt_up = 4'hF; tick();
        check("rst_count", 32'(|count_out), 0);
        check("rst_done", 32'(batch_done), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_tally", batch_tally, 0);
        check("rst_any", 32'(any_done), 0);
        check("rst_tally2", 32'(tally2), 0);
        rst = 1'b0; cnt_up = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_batch_sample_counter
`default_nettype wire
